// File: rtl/conv_out_fsm_pkg.sv
// conv_out_pkg: shared constants for the convolution result-side controller.
// State encoding, default widths and the default BRAM read latency.
package conv_out_pkg;

  localparam int DEF_NB_ADDRESS = 10;
  localparam int DEF_NB_IMAGE   = 10;
  localparam int DEF_RD_LAT     = 1;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

endpackage

// File: rtl/conv_out_fsm_addr_counter.sv
// addr_counter: saturating up-counter used for the BRAM write and read
// addresses. Reports saturation, "count equals term" and "count after this
// cycle's increment equals term" so the parent can close a block or spot the
// last read in the same cycle as the access.
module addr_counter
  import conv_out_pkg::*;
#(
  parameter int W  = DEF_NB_ADDRESS,
  parameter int TW = DEF_NB_ADDRESS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [TW-1:0] term,
  output logic [W-1:0]  count,
  output logic          at_max,
  output logic          at_term,
  output logic          hit
);

  // Compare in a width wide enough for both operands plus the carry.
  localparam int CW = ((W > TW) ? W : TW) + 1;

  logic          inc;
  logic [CW-1:0] count_x;
  logic [CW-1:0] term_x;
  logic [CW-1:0] next_x;

  assign at_max  = &count;
  assign inc     = en & ~at_max;
  assign count_x = CW'(count);
  assign term_x  = CW'(term);
  assign next_x  = count_x + CW'(inc);
  assign at_term = (count_x == term_x);
  assign hit     = (next_x == term_x);

  // Counter register: clear wins over increment; holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/conv_out_fsm.sv
// conv_out_fsm: collects convolver output pixels into an output BRAM block and
// lets the host read the block back one word per request.
// Optional build macro CONV_OUT_FSM_OVERRUN_FLAG_EN adds a sticky o_overrun
// flag for pixels dropped in READY/DRAIN or at write-address saturation.
//
// Strobe semantics: every input strobe (i_convVld, i_rdReq, i_changeBlock,
// i_EoP) is a per-cycle qualifier sampled on the rising edge; there is no
// back-pressure. A pixel is stored exactly when o_writeEn is high in that
// cycle; a read request is accepted only in READY while o_blockReady is high,
// and each accepted request yields one o_dataVld RD_LAT cycles after its
// o_readAdd is issued. o_EoR/o_EoP are single-cycle pulses aligned with the
// last o_dataVld of the block.
module conv_out_fsm
  import conv_out_pkg::*;
#(
  parameter int NB_ADDRESS = DEF_NB_ADDRESS,
  parameter int NB_IMAGE   = DEF_NB_IMAGE,
  parameter int RD_LAT     = DEF_RD_LAT   // must be >= 1
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic                  i_convVld,
  input  logic                  i_changeBlock,
  input  logic                  i_EoP,
  input  logic [NB_IMAGE-1:0]   i_imgLength,
  input  logic                  i_rdReq,
  output logic [NB_ADDRESS-1:0] o_writeAdd,
  output logic                  o_writeEn,
  output logic [NB_ADDRESS-1:0] o_readAdd,
  output logic                  o_dataVld,
  output logic                  o_blockReady,
  output logic                  o_EoR,
  output logic                  o_EoP,
`ifdef CONV_OUT_FSM_OVERRUN_FLAG_EN
  output logic                  o_overrun,
`endif
  output logic [1:0]            o_state
);

  state_t                state;
  logic [NB_IMAGE-1:0]   len_q;
  logic [NB_ADDRESS-1:0] cnt_q;
  logic                  eop_flag;
  logic                  block_ready;
  logic [NB_ADDRESS-1:0] read_add;
  logic [RD_LAT:0]       vld_sr;
  logic [RD_LAT:0]       last_sr;
  logic [RD_LAT:0]       eop_sr;

  logic                  in_idle, in_collect, in_ready, in_drain;
  logic                  wr_en, close, rd_accept, rd_last, drain_done;
  logic [NB_ADDRESS-1:0] wr_cnt, rd_cnt;
  logic                  wr_at_max, wr_at_term, wr_hit;
  logic                  rd_at_max, rd_at_term, rd_hit;

  assign in_idle    = (state == ST_IDLE);
  assign in_collect = (state == ST_COLLECT);
  assign in_ready   = (state == ST_READY);
  assign in_drain   = (state == ST_DRAIN);

  // A write is suppressed once the address saturates, or (length 1 only) when
  // the latched length was already reached by the write made in IDLE.
  assign wr_en = i_convVld & (in_idle | (in_collect & ~wr_at_max & ~wr_at_term));

  // wr_hit already counts this cycle's write, so a pixel arriving together
  // with a close event is stored and included in the block length.
  assign close = in_collect & (i_changeBlock | i_EoP | wr_hit);

  // rd_at_term/rd_at_max cannot be true in READY; they keep a stray request
  // from ever addressing past the block.
  assign rd_accept  = in_ready & i_rdReq & ~rd_at_term & ~rd_at_max;
  assign rd_last    = rd_accept & rd_hit;
  assign drain_done = in_drain & last_sr[RD_LAT-1];

  addr_counter #(.W(NB_ADDRESS), .TW(NB_IMAGE)) u_wr_cnt (
    .clk     (i_CLK),
    .rst     (i_reset),
    .clear   (drain_done),
    .en      (wr_en),
    .term    (len_q),
    .count   (wr_cnt),
    .at_max  (wr_at_max),
    .at_term (wr_at_term),
    .hit     (wr_hit)
  );

  addr_counter #(.W(NB_ADDRESS), .TW(NB_ADDRESS)) u_rd_cnt (
    .clk     (i_CLK),
    .rst     (i_reset),
    .clear   (drain_done),
    .en      (rd_accept),
    .term    (cnt_q),
    .count   (rd_cnt),
    .at_max  (rd_at_max),
    .at_term (rd_at_term),
    .hit     (rd_hit)
  );

  // Block lifecycle: IDLE -> COLLECT -> READY -> DRAIN -> IDLE.
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      eop_flag    <= 1'b0;
      block_ready <= 1'b0;
      read_add    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_en) begin
            len_q <= i_imgLength;
            state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (close) begin
            cnt_q       <= wr_cnt + NB_ADDRESS'(wr_en);
            eop_flag    <= i_EoP;
            block_ready <= 1'b1;
            state       <= ST_READY;
          end
        end
        ST_READY: begin
          if (rd_accept) read_add <= rd_cnt;
          if (rd_last) begin
            block_ready <= 1'b0;
            state       <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            eop_flag <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Delay lines modelling the BRAM read latency for valid and end strobes.
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      vld_sr  <= '0;
      last_sr <= '0;
      eop_sr  <= '0;
    end else begin
      vld_sr  <= {vld_sr[RD_LAT-1:0], rd_accept};
      last_sr <= {last_sr[RD_LAT-1:0], rd_last};
      eop_sr  <= {eop_sr[RD_LAT-1:0], rd_last & eop_flag};
    end
  end

`ifdef CONV_OUT_FSM_OVERRUN_FLAG_EN
  // Sticky record of any pixel that was dropped; only reset clears it.
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      o_overrun <= 1'b0;
    end else if (i_convVld & (in_ready | in_drain | (in_collect & wr_at_max))) begin
      o_overrun <= 1'b1;
    end
  end
`endif

  assign o_writeAdd   = wr_cnt;
  assign o_writeEn    = wr_en;
  assign o_readAdd    = read_add;
  assign o_dataVld    = vld_sr[RD_LAT];
  assign o_blockReady = block_ready;
  assign o_EoR        = last_sr[RD_LAT];
  assign o_EoP        = eop_sr[RD_LAT];
  assign o_state      = state;

endmodule
